// File: rtl/distance_alarm.sv
// Ultrasonic distance alarm: clamp and average samples, classify into zones, drive LEDs and buzzer.
// Optional 4-sample averaging filter is enabled by defining DISTANCE_ALARM_AVG_FILTER_EN.
module distance_alarm #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NEAR_CM    = 10,
  parameter int MID_CM     = 30,
  parameter int FAR_CM     = 100,
  parameter int HYST_CM    = 2,
  parameter int TIMEOUT_MS = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dist_valid,
  input  logic [15:0] dist_in,
  output logic [15:0] avg_dist,
  output logic        avg_valid,
  output logic [1:0]  zone,
  output logic [7:0]  led_bar,
  output logic        buzzer,
  output logic        timeout
);

  localparam logic [1:0] ZONE_SAFE = 2'd0;
  localparam logic [1:0] ZONE_FAR  = 2'd1;
  localparam logic [1:0] ZONE_MID  = 2'd2;
  localparam logic [1:0] ZONE_NEAR = 2'd3;

  localparam longint unsigned TO_CYC   = 64'(TIMEOUT_MS) * 64'(CLK_HZ) / 64'd1000;
  localparam int              TOW      = $clog2(TO_CYC + 64'd1);
  localparam logic [TOW-1:0]  TO_TERM  = TOW'(TO_CYC);
  localparam longint unsigned FAR_HALF = 64'd250 * 64'(CLK_HZ) / 64'd1000;
  localparam longint unsigned MID_HALF = 64'd100 * 64'(CLK_HZ) / 64'd1000;
  localparam int              BW       = $clog2(FAR_HALF + 64'd1);
  localparam logic [BW-1:0]   FAR_LAST = BW'(FAR_HALF - 64'd1);
  localparam logic [BW-1:0]   MID_LAST = BW'(MID_HALF - 64'd1);

  logic [15:0]    clamped;
  logic [TOW-1:0] gap_q, gap_d;
  logic           timeout_q, timeout_d;
  logic           expire;
  logic [15:0]    avg_dist_q, avg_dist_d;
  logic           avg_valid_q, avg_valid_d;
  logic [1:0]     zone_q, zone_d, target;
  logic [16:0]    exit_thr;
  logic [BW-1:0]  beep_cnt_q, beep_cnt_d, beep_last;
  logic           beep_on_q, beep_on_d;

  assign clamped = (dist_in > 16'd400) ? 16'd400 : dist_in;

  // A sample arriving on the expiry cycle wins, so expiry requires no strobe.
  always_comb begin
    expire    = !dist_valid && (gap_q == TO_TERM - TOW'(1));
    gap_d     = gap_q;
    timeout_d = timeout_q;
    if (dist_valid) begin
      gap_d     = '0;
      timeout_d = 1'b0;
    end else begin
      if (gap_q != TO_TERM) gap_d = gap_q + TOW'(1);
      if (expire) timeout_d = 1'b1;
    end
  end

`ifdef DISTANCE_ALARM_AVG_FILTER_EN
  logic [3:0][15:0] fifo_q, fifo_d;
  logic [17:0]      sum_q, sum_d;
  logic [2:0]       fill_q, fill_d;

  // FIFO starts zeroed, so subtracting the oldest entry is correct while filling.
  always_comb begin
    fifo_d      = fifo_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_valid_d = 1'b0;
    avg_dist_d  = avg_dist_q;
    if (expire) begin
      fifo_d = '0;
      sum_d  = '0;
      fill_d = '0;
    end else if (dist_valid) begin
      fifo_d = {fifo_q[2:0], clamped};
      sum_d  = sum_q + 18'(clamped) - 18'(fifo_q[3]);
      fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
      if (fill_d == 3'd4) begin
        avg_valid_d = 1'b1;
        avg_dist_d  = 16'(sum_d >> 2);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      fifo_q <= fifo_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end
`else
  always_comb begin
    avg_valid_d = dist_valid;
    avg_dist_d  = dist_valid ? clamped : avg_dist_q;
  end
`endif

  always_comb begin
    if (avg_dist_q < 16'(NEAR_CM))     target = ZONE_NEAR;
    else if (avg_dist_q < 16'(MID_CM)) target = ZONE_MID;
    else if (avg_dist_q < 16'(FAR_CM)) target = ZONE_FAR;
    else                               target = ZONE_SAFE;
  end

  always_comb begin
    case (zone_q)
      ZONE_NEAR: exit_thr = 17'(NEAR_CM + HYST_CM);
      ZONE_MID:  exit_thr = 17'(MID_CM + HYST_CM);
      ZONE_FAR:  exit_thr = 17'(FAR_CM + HYST_CM);
      default:   exit_thr = '1;
    endcase
  end

  // Moving nearer is immediate; moving farther must clear the current zone's hysteresis band.
  always_comb begin
    zone_d = zone_q;
    if (expire) begin
      zone_d = ZONE_SAFE;
    end else if (avg_valid_q) begin
      if (target > zone_q) begin
        zone_d = target;
      end else if ((target < zone_q) && ({1'b0, avg_dist_q} >= exit_thr)) begin
        zone_d = target;
      end
    end
  end

  assign beep_last = (zone_q == ZONE_MID) ? MID_LAST : FAR_LAST;

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    beep_on_d  = beep_on_q;
    if (zone_d != zone_q) begin
      beep_cnt_d = '0;
      beep_on_d  = 1'b1;
    end else if (beep_cnt_q >= beep_last) begin
      beep_cnt_d = '0;
      beep_on_d  = !beep_on_q;
    end else begin
      beep_cnt_d = beep_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q       <= '0;
      timeout_q   <= 1'b0;
      avg_dist_q  <= '0;
      avg_valid_q <= 1'b0;
      zone_q      <= ZONE_SAFE;
      beep_cnt_q  <= '0;
      beep_on_q   <= 1'b1;
    end else begin
      gap_q       <= gap_d;
      timeout_q   <= timeout_d;
      avg_dist_q  <= avg_dist_d;
      avg_valid_q <= avg_valid_d;
      zone_q      <= zone_d;
      beep_cnt_q  <= beep_cnt_d;
      beep_on_q   <= beep_on_d;
    end
  end

  always_comb begin
    if (timeout_q) begin
      led_bar = 8'h00;
      buzzer  = 1'b0;
    end else begin
      case (zone_q)
        ZONE_FAR:  begin led_bar = 8'b0000_1111; buzzer = beep_on_q; end
        ZONE_MID:  begin led_bar = 8'b0011_1111; buzzer = beep_on_q; end
        ZONE_NEAR: begin led_bar = 8'b1111_1111; buzzer = 1'b1;      end
        default:   begin led_bar = 8'b0000_0001; buzzer = 1'b0;      end
      endcase
    end
  end

  assign avg_dist  = avg_dist_q;
  assign avg_valid = avg_valid_q;
  assign zone      = zone_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_distance_alarm.sv
// Self-checking bench for distance_alarm: directed scenarios plus a random walk,
// compared every cycle against a queue-based reference model.
module tb_distance_alarm;
  localparam int CLK_HZ   = 10_000;
  localparam int TERM     = 200 * CLK_HZ / 1000;
  localparam int FAR_HALF = 250 * CLK_HZ / 1000;
  localparam int MID_HALF = 100 * CLK_HZ / 1000;

  logic        clk;
  logic        reset_n;
  logic        dist_valid;
  logic [15:0] dist_in;
  logic [15:0] avg_dist;
  logic        avg_valid;
  logic [1:0]  zone;
  logic [7:0]  led_bar;
  logic        buzzer;
  logic        timeout;

  distance_alarm #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset_n(reset_n), .dist_valid(dist_valid), .dist_in(dist_in),
    .avg_dist(avg_dist), .avg_valid(avg_valid), .zone(zone), .led_bar(led_bar),
    .buzzer(buzzer), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int validCount = 0;

  int hist[$];
  int nSince, expAvg, zoneM, gap, zoneAge;
  bit expValid, toM;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int zoneRule(input int cur, input int a);
    int t, thr;
    t = (a < 10) ? 3 : (a < 30) ? 2 : (a < 100) ? 1 : 0;
    thr = (cur == 3) ? 10 : (cur == 2) ? 30 : 100;
    if (t > cur) return t;
    if (t < cur && a >= thr + 2) return t;
    return cur;
  endfunction

  function automatic int ledFor(input int z);
    case (z)
      1: return 8'h0F;
      2: return 8'h3F;
      3: return 8'hFF;
      default: return 8'h01;
    endcase
  endfunction

  function automatic int buzzFor(input int z, input int age);
    case (z)
      1: return ((age / FAR_HALF) % 2 == 0) ? 1 : 0;
      2: return ((age / MID_HALF) % 2 == 0) ? 1 : 0;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int expFills(input int k);
`ifdef DISTANCE_ALARM_AVG_FILTER_EN
    return (k >= 4) ? k - 3 : 0;
`else
    return k;
`endif
  endfunction

  task automatic modelReset();
    hist.delete();
    nSince = 0; expAvg = 0; expValid = 0; zoneM = 0; gap = 0; toM = 0; zoneAge = 0;
  endtask

  task automatic modelStep(input bit v, input int d);
    int nz, c, s;
    bit expired;
    nz = expValid ? zoneRule(zoneM, expAvg) : zoneM;
    expired = 0;
    if (v) gap = 0;
    else if (gap < TERM) begin
      gap++;
      if (gap == TERM) expired = 1;
    end
    toM = (gap == TERM);
    if (expired) begin
      hist.delete();
      nSince = 0;
      nz = 0;
    end
    if (nz != zoneM) zoneAge = 0; else zoneAge++;
    zoneM = nz;
    expValid = 0;
    if (v) begin
      c = (d > 400) ? 400 : d;
`ifdef DISTANCE_ALARM_AVG_FILTER_EN
      hist.push_back(c);
      if (hist.size() > 4) void'(hist.pop_front());
      if (nSince < 4) nSince++;
      if (nSince == 4) begin
        s = 0;
        foreach (hist[i]) s += hist[i];
        expAvg = s / 4;
        expValid = 1;
      end
`else
      expAvg = c;
      expValid = 1;
`endif
    end
  endtask

  task automatic compareAll();
    checkOutput("avg_valid", avg_valid, expValid);
    checkOutput("avg_dist", avg_dist, expAvg);
    checkOutput("zone", zone, zoneM);
    checkOutput("timeout", timeout, toM);
    checkOutput("led_bar", led_bar, toM ? 0 : ledFor(zoneM));
    checkOutput("buzzer", buzzer, toM ? 0 : buzzFor(zoneM, zoneAge));
  endtask

  task automatic applyStimulus(input bit v, input int d);
    @(negedge clk);
    if (reset_n) compareAll();
    dist_valid = v;
    dist_in = 16'(d);
    @(posedge clk);
    #1;
    if (reset_n) modelStep(v, d);
    if (avg_valid === 1'b1) validCount++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, $urandom_range(0, 2000));
  endtask

  task automatic sendSamples(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, d);
      idle(3);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    dist_valid = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_avg_dist", avg_dist, 0);
    checkOutput("rst_avg_valid", avg_valid, 0);
    checkOutput("rst_zone", zone, 0);
    checkOutput("rst_led_bar", led_bar, 8'h01);
    checkOutput("rst_buzzer", buzzer, 0);
    checkOutput("rst_timeout", timeout, 0);
    repeat (3) applyStimulus(0, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    int toggles[$];
    logic lastBuzz;
    int walk;
    reset_n = 1'b1;
    dist_valid = 1'b0;
    dist_in = '0;
    modelReset();
    doReset();

    // 4x40 -> FAR, then hold FAR to watch the 250 ms beep
    validCount = 0;
    sendSamples(40, 4);
    checkOutput("far_fills", validCount, expFills(4));
    checkOutput("far_avg", avg_dist, 40);
    checkOutput("far_zone", zone, 1);
    checkOutput("far_led", led_bar, 8'h0F);
    lastBuzz = buzzer;
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) applyStimulus(1, 40);
      else applyStimulus(0, $urandom_range(0, 2000));
      if (buzzer !== lastBuzz) toggles.push_back(i);
      lastBuzz = buzzer;
    end
    checkOutput("far_toggles", (toggles.size() >= 2) ? 1 : 0, 1);
    checkOutput("far_period", (toggles.size() >= 2) ? toggles[1] - toggles[0] : 0, FAR_HALF);

    sendSamples(8, 4);
    checkOutput("near_zone", zone, 3);
    checkOutput("near_led", led_bar, 8'hFF);
    checkOutput("near_buzz", buzzer, 1);

    sendSamples(20, 4);
    sendSamples(31, 4);
    checkOutput("hyst_hold_mid", zone, 2);
    sendSamples(32, 4);
    checkOutput("hyst_to_far", zone, 1);

    sendSamples(1000, 4);
    checkOutput("clamp_avg", avg_dist, 400);
    checkOutput("clamp_zone", zone, 0);

    idle(TERM + 20);
    checkOutput("to_flag", timeout, 1);
    checkOutput("to_led", led_bar, 8'h00);
    checkOutput("to_buzz", buzzer, 0);
    checkOutput("to_zone", zone, 0);
    validCount = 0;
    applyStimulus(1, 50);
    checkOutput("to_clear", timeout, 0);
    idle(3);
    sendSamples(50, 2);
    checkOutput("to_refill3", validCount, expFills(3));
    sendSamples(50, 1);
    checkOutput("to_refill4", validCount, expFills(4));

    applyStimulus(1, 60);
    idle(TERM - 1);
    applyStimulus(1, 60);
    checkOutput("expiry_tie", timeout, 0);

    validCount = 0;
    sendSamples(70, 3);
    doReset();
    validCount = 0;
    sendSamples(5, 3);
    checkOutput("rst_refill3", validCount, expFills(3));
    sendSamples(5, 1);
    checkOutput("rst_refill4", validCount, expFills(4));

    walk = 60;
    for (int n = 0; n < 400; n++) begin
      walk += $urandom_range(0, 30) - 15;
      if (walk < 0) walk = 0;
      if (walk > 140) walk = 140;
      applyStimulus(1, ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1500) : walk);
      if ($urandom_range(0, 99) == 0) idle(TERM + 10);
      else idle($urandom_range(0, 40));
    end
    applyStimulus(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/distance_alarm.md
DISTANCE_ALARM -- requirements
Module: distance_alarm

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter NEAR_CM, default 10, near-zone threshold in cm.
REQ-003 SHALL have parameter MID_CM, default 30, mid-zone threshold in cm.
REQ-004 SHALL have parameter FAR_CM, default 100, far-zone threshold in cm.
REQ-005 SHALL have parameter HYST_CM, default 2, zone-exit hysteresis in cm.
REQ-006 SHALL have parameter TIMEOUT_MS, default 200, maximum gap between samples before timeout.
REQ-007 SHALL have port clk, input, 1, the single system clock; all logic on posedge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port dist_valid, input, 1, one-cycle strobe marking a new distance sample.
REQ-010 SHALL have port dist_in, input, 16, distance in cm from the ultrasonic ranger; sampled only when dist_valid=1.
REQ-011 SHALL have port avg_dist, output, 16, filtered distance in cm.
REQ-012 SHALL have port avg_valid, output, 1, one-cycle strobe when avg_dist updates.
REQ-013 SHALL have port zone, output, 2, current zone: 0=SAFE, 1=FAR, 2=MID, 3=NEAR.
REQ-014 SHALL have port led_bar, output, 8, zone bar graph.
REQ-015 SHALL have port buzzer, output, 1, beep drive.
REQ-016 SHALL have port timeout, output, 1, high while no sample has arrived within TIMEOUT_MS.

Function
REQ-017 SHALL clamp dist_in above 400 to 400 before any use.
REQ-018 SHALL keep a 4-entry sample FIFO plus an 18-bit running sum: on each sample, sum += new - oldest; avg_dist = sum>>2 (truncating).
REQ-019 SHALL hold avg_valid low until 4 samples have been collected since reset or timeout (fill count 0..4, saturating).
REQ-020 SHALL register avg_dist and pulse avg_valid exactly 1 cycle after the qualifying dist_valid.
REQ-021 SHALL evaluate the zone FSM (SAFE/FAR/MID/NEAR) only on cycles where avg_valid=1.
REQ-022 SHALL enter any nearer zone directly when avg_dist < that zone's threshold: NEAR<NEAR_CM, MID<MID_CM, FAR<FAR_CM.
REQ-023 SHALL leave a zone for a farther one only when avg_dist >= that zone's threshold+HYST_CM; the target is the nearest zone whose entry condition still holds, else SAFE.
REQ-024 SHALL drive led_bar from zone: SAFE 8'b0000_0001, FAR 8'b0000_1111, MID 8'b0011_1111, NEAR 8'b1111_1111.
REQ-025 SHALL drive buzzer by zone: SAFE 0; FAR 250 ms on / 250 ms off; MID 100 ms on / 100 ms off; NEAR constant 1.
REQ-026 SHALL restart each beep pattern in its on-phase on every zone change.
REQ-027 SHALL count clk cycles since the last dist_valid, saturating at the terminal count; reaching TIMEOUT_MS*CLK_HZ/1000 sets timeout=1.
REQ-028 SHALL, on timeout, force zone=SAFE, buzzer=0 and led_bar=8'h00, and clear fill count and sum.
REQ-029 SHALL clear timeout and restart the gap counter on the next dist_valid; when dist_valid coincides with expiry, the sample wins and timeout stays 0.

Reset
REQ-030 SHALL, while reset_n=0, immediately force avg_dist=0, avg_valid=0, zone=SAFE, led_bar=8'b0000_0001, buzzer=0, timeout=0, and clear FIFO, sum, fill count and all timers.
REQ-031 SHALL discard any partially filled average when reset is asserted mid-operation; the first avg_valid after release follows the 4th new sample.

Configuration
REQ-032 SHALL, when macro DISTANCE_ALARM_AVG_FILTER_EN is defined, include the 4-sample filter per REQ-018..REQ-020.
REQ-033 SHALL, when DISTANCE_ALARM_AVG_FILTER_EN is undefined, omit the FIFO: avg_dist = clamped dist_in, and avg_valid pulses 1 cycle after every dist_valid, with no fill requirement.

Verification (CLK_HZ=1_000_000, other parameters default, filter enabled)
REQ-034 SHALL cover: samples 40,40,40,40 -> a single avg_valid after the 4th sample, avg_dist=40, zone=FAR, led_bar=0x0F, buzzer toggles every 250_000 cycles.
REQ-035 SHALL cover: 4x sample 8 from SAFE -> zone=NEAR, buzzer constant 1, led_bar=0xFF.
REQ-036 SHALL cover hysteresis: from MID, avg_dist=31 keeps MID; avg_dist=32 moves to FAR.
REQ-037 SHALL cover clamping: 4x sample 1000 -> avg_dist=400, zone=SAFE.
REQ-038 SHALL cover timeout: no dist_valid for 200_000 cycles -> timeout=1, led_bar=0x00, buzzer=0; the next sample clears timeout, and avg_valid returns only after 4 samples.
REQ-039 SHALL cover reset: reset_n pulsed low after 3 samples -> all outputs at reset values; 4 further samples are needed for avg_valid.
